// File: rtl/lorenz_pkg.sv
// Shared fixed-point types and helpers for the Lorenz step sequencer.
// LORENZ_CLAMP_EN selects saturating narrowing; otherwise narrowing wraps.
package lorenz_pkg;

  localparam int LZ_W     = 32;
  localparam int LZ_FRAC  = 16;
  localparam int LZ_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_UPD,
    ST_OUT,
    ST_FIN
  } lz_state_t;

  // Product slots; k4..k6 consume results of k0..k3.
  typedef enum logic [2:0] {
    K_SDX = 3'd0,
    K_XRZ = 3'd1,
    K_XY  = 3'd2,
    K_BZ  = 3'd3,
    K_DTX = 3'd4,
    K_DTY = 3'd5,
    K_DTZ = 3'd6
  } lz_prod_t;

  localparam logic signed [2*LZ_W-1:0] LZ_WIDE_MAX = {{(LZ_W+1){1'b0}}, {(LZ_W-1){1'b1}}};
  localparam logic signed [2*LZ_W-1:0] LZ_WIDE_MIN = {{(LZ_W+1){1'b1}}, {(LZ_W-1){1'b0}}};

  function automatic logic signed [LZ_W-1:0] sat_narrow(input logic signed [2*LZ_W-1:0] v);
    if (v > LZ_WIDE_MAX)
      return {1'b0, {(LZ_W-1){1'b1}}};
    else if (v < LZ_WIDE_MIN)
      return {1'b1, {(LZ_W-1){1'b0}}};
    else
      return v[LZ_W-1:0];
  endfunction

  function automatic logic signed [LZ_W-1:0] lz_narrow(input logic signed [2*LZ_W-1:0] v);
`ifdef LORENZ_CLAMP_EN
    return sat_narrow(v);
`else
    return v[LZ_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/lorenz_fx_mul.sv
// Signed fixed-point multiply: full product, floor shift by FRAC, narrow to W.
// Purely combinational; the sequencer registers the result.
module lorenz_fx_mul
  import lorenz_pkg::*;
#(
  parameter int W    = LZ_W,
  parameter int FRAC = LZ_FRAC
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  logic signed [2*W-1:0] full;

  assign full = $signed(a) * $signed(b);
  assign p    = lz_narrow(full >>> FRAC);

endmodule

// File: rtl/lorenz_step_sequencer.sv
// Forward-Euler Lorenz stepper on one shared multiplier (LORENZ_CLAMP_EN: saturating math).
// 9 cycles per sample (7 MUL + UPD + OUT); OUT holds until out_ready, abort returns to IDLE.
module lorenz_step_sequencer
  import lorenz_pkg::*;
#(
  parameter int W     = LZ_W,
  parameter int FRAC  = LZ_FRAC,
  parameter int CNT_W = LZ_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [W-1:0]     init_x,
  input  logic [W-1:0]     init_y,
  input  logic [W-1:0]     init_z,
  input  logic [W-1:0]     sigma,
  input  logic [W-1:0]     rho,
  input  logic [W-1:0]     beta,
  input  logic [W-1:0]     dt,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic [W-1:0]     out_z,
  output logic [CNT_W-1:0] step_idx
);

  lz_state_t        state;
  lz_prod_t         k;
  logic [CNT_W-1:0] nsteps;
  logic [W-1:0]     x, y, z;
  logic [W-1:0]     sigma_q, rho_q, beta_q, dt_q;
  logic [W-1:0]     p [7];

  logic [W-1:0]     sub_a, sub_b, diff;
  logic [W-1:0]     mul_a, mul_b, mul_p;
  logic [W-1:0]     nx, ny, nz;

  function automatic logic [W-1:0] add_n(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic neg);
    logic [2*W-1:0] ea, eb;
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
    return lz_narrow(neg ? ea - eb : ea + eb);
  endfunction

  // One subtractor shared by every slot that needs a difference operand.
  always_comb begin
    sub_a = '0;
    sub_b = '0;
    case (k)
      K_SDX:   begin sub_a = y;     sub_b = x;    end
      K_XRZ:   begin sub_a = rho_q; sub_b = z;    end
      K_DTY:   begin sub_a = p[1];  sub_b = y;    end
      K_DTZ:   begin sub_a = p[2];  sub_b = p[3]; end
      default: begin sub_a = '0;    sub_b = '0;   end
    endcase
  end

  assign diff = add_n(sub_a, sub_b, 1'b1);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (k)
      K_SDX:   begin mul_a = sigma_q; mul_b = diff; end
      K_XRZ:   begin mul_a = x;       mul_b = diff; end
      K_XY:    begin mul_a = x;       mul_b = y;    end
      K_BZ:    begin mul_a = beta_q;  mul_b = z;    end
      K_DTX:   begin mul_a = dt_q;    mul_b = p[0]; end
      K_DTY:   begin mul_a = dt_q;    mul_b = diff; end
      K_DTZ:   begin mul_a = dt_q;    mul_b = diff; end
      default: begin mul_a = '0;      mul_b = '0;   end
    endcase
  end

  lorenz_fx_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  assign nx = add_n(x, p[4], 1'b0);
  assign ny = add_n(y, p[5], 1'b0);
  assign nz = add_n(z, p[6], 1'b0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      k         <= K_SDX;
      nsteps    <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      sigma_q   <= '0;
      rho_q     <= '0;
      beta_q    <= '0;
      dt_q      <= '0;
      for (int i = 0; i < 7; i++) p[i] <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      step_idx  <= '0;
    end else if (abort) begin
      // Sample outputs deliberately keep their last values.
      state     <= ST_IDLE;
      k         <= K_SDX;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            nsteps   <= num_steps;
            x        <= init_x;
            y        <= init_y;
            z        <= init_z;
            sigma_q  <= sigma;
            rho_q    <= rho;
            beta_q   <= beta;
            dt_q     <= dt;
            step_idx <= '0;
            k        <= K_SDX;
            busy     <= 1'b1;
            if (num_steps == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          p[k] <= mul_p;
          if (k == K_DTZ) begin
            k     <= K_SDX;
            state <= ST_UPD;
          end else begin
            k <= lz_prod_t'(k + 3'd1);
          end
        end
        ST_UPD: begin
          x         <= nx;
          y         <= ny;
          z         <= nz;
          out_x     <= nx;
          out_y     <= ny;
          out_z     <= nz;
          step_idx  <= step_idx + 1'b1;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (step_idx < nsteps) begin
              state <= ST_MUL;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lorenz_step_sequencer.sv
// Scoreboard bench for lorenz_step_sequencer: directed runs with hand-computed samples.
module tb_lorenz_step_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, out_ready;
  logic [15:0] num_steps;
  logic [31:0] init_x, init_y, init_z, sigma, rho, beta, dt;
  logic        busy, done, out_valid;
  logic [31:0] out_x, out_y, out_z;
  logic [15:0] step_idx;

  always #5 clk = ~clk;

  lorenz_step_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .num_steps (num_steps),
    .init_x    (init_x),
    .init_y    (init_y),
    .init_z    (init_z),
    .sigma     (sigma),
    .rho       (rho),
    .beta      (beta),
    .dt        (dt),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .step_idx  (step_idx)
  );

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [15:0] idx;
  } smp_t;

  smp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   d0;

  localparam smp_t S1 = '{x: 32'h0001_0000, y: 32'h0001_4286, z: 32'h0000_FBBC, idx: 16'd1};
  localparam smp_t S2 = '{x: 32'h0001_06A6, y: 32'h0001_846C, z: 32'h0000_F83F, idx: 16'd2};
  localparam smp_t S3 = '{x: 32'h0001_1338, y: 32'h0001_C77E, z: 32'h0000_F59C, idx: 16'd3};

`ifdef LORENZ_CLAMP_EN
  localparam logic [31:0] CLAMP_X = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] CLAMP_X = 32'hFFFE_0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with out_valid high must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_x", out_x, q[0].x);
          chk("out_y", out_y, q[0].y);
          chk("out_z", out_z, q[0].z);
          chk("step_idx", {16'd0, step_idx}, {16'd0, q[0].idx});
          if (out_ready === 1'b1) q.delete(0);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] ix, iy, iz, sg, rh, bt, dd, input logic [15:0] n);
    init_x = ix; init_y = iy; init_z = iz;
    sigma = sg; rho = rh; beta = bt; dt = dd;
    num_steps = n;
  endtask

  task automatic load_s1(input logic [15:0] n);
    load(32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
         32'h000A_0000, 32'h001C_0000, 32'h0002_AAAB, 32'h0000_028F, n);
  endtask

  // Inputs are scrambled after the start edge to prove they were latched.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    load(32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D,
         32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0001_0000, 16'h00FF);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 60 && out_valid !== 1'b1; i++) tick();
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    load('0, '0, '0, '0, '0, '0, '0, '0);
    tick(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_x", out_x, 32'd0);
    chk("rst_y", out_y, 32'd0);
    chk("rst_z", out_z, 32'd0);
    chk("rst_idx", {16'd0, step_idx}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single step, exact latency.
    out_ready = 1'b1;
    load_s1(16'd1);
    q.push_back(S1);
    d0 = done_cnt;
    pulse_start();
    tick(7);
    chk("s1_valid_e8", {31'd0, out_valid}, 32'd0);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("s1_valid_e9", {31'd0, out_valid}, 32'd1);
    tick();
    chk("s1_valid_e10", {31'd0, out_valid}, 32'd0);
    chk("s1_done", {31'd0, done}, 32'd1);
    tick();
    chk("s1_done_end", {31'd0, done}, 32'd0);
    chk("s1_busy_end", {31'd0, busy}, 32'd0);
    chk("s1_done_cnt", done_cnt - d0, 32'd1);

    // Three steps with 5-cycle stalls on each sample.
    out_ready = 1'b0;
    load_s1(16'd3);
    q.push_back(S1); q.push_back(S2); q.push_back(S3);
    d0 = done_cnt;
    pulse_start();
    for (int s = 0; s < 3; s++) begin
      wait_valid("s2_valid");
      tick(5);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("s2_done", {31'd0, done}, 32'd1);
    tick(2);
    chk("s2_done_cnt", done_cnt - d0, 32'd1);
    chk("s2_busy_end", {31'd0, busy}, 32'd0);
    chk("s2_queue", q.size(), 32'd0);

    // Zero steps.
    load_s1(16'd0);
    d0 = done_cnt;
    pulse_start();
    chk("s0_done", {31'd0, done}, 32'd1);
    chk("s0_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("s0_done_end", {31'd0, done}, 32'd0);
    chk("s0_busy_end", {31'd0, busy}, 32'd0);
    chk("s0_done_cnt", done_cnt - d0, 32'd1);

    // Abort during k3 of step 2, then restart.
    out_ready = 1'b1;
    load_s1(16'd3);
    q.push_back(S1);
    d0 = done_cnt;
    pulse_start();
    wait_valid("ab_valid");
    tick(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_valid_low", {31'd0, out_valid}, 32'd0);
    chk("ab_hold_x", out_x, S1.x);
    chk("ab_hold_y", out_y, S1.y);
    tick(3);
    chk("ab_no_done", done_cnt - d0, 32'd0);
    load_s1(16'd1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("ab_beats_start", {31'd0, busy}, 32'd0);
    load_s1(16'd1);
    q.push_back(S1);
    pulse_start();
    tick(3);
    load(32'h0005_0000, 32'h0006_0000, 32'h0007_0000,
         32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 16'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("re_valid");
    tick(3);
    chk("re_done_cnt", done_cnt - d0, 32'd1);
    chk("re_busy_end", {31'd0, busy}, 32'd0);

    // Overflow of sigma*(y-x): saturate or wrap.
    load(32'h0000_0000, 32'h7FFF_0000, 32'h0000_0000,
         32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 16'd1);
    q.push_back('{x: CLAMP_X, y: 32'd0, z: 32'd0, idx: 16'd1});
    pulse_start();
    wait_valid("ov_valid");
    tick(3);
    chk("queue_drained", q.size(), 32'd0);

    // Reset while a sample is presented.
    out_ready = 1'b0;
    load_s1(16'd2);
    q.push_back(S1);
    pulse_start();
    wait_valid("rs_valid");
    reset_n = 1'b0;
    tick();
    q.delete();
    chk("rs_valid_low", {31'd0, out_valid}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_x", out_x, 32'd0);
    chk("rs_y", out_y, 32'd0);
    chk("rs_z", out_z, 32'd0);
    chk("rs_idx", {16'd0, step_idx}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lorenz_step_sequencer.md
# lorenz_step_sequencer

Sequencer that runs N forward-Euler steps of the Lorenz system on signed fixed-point state through one shared multiplier. Accepts a start command with initial state and parameters, time-multiplexes the multiplier over the seven products each step needs, and streams each new (x, y, z) sample to the downstream reservoir-input stage over a valid/ready handshake. Sits between the host/config registers and the reservoir feature pipeline.

## Interface
- W, 32, data width (signed, two's complement)
- FRAC, 16, fractional bits (Q16.16 at defaults; 1.0 = 0x0001_0000)
- CNT_W, 16, width of step count and index
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  command pulse; accepted only in IDLE
- abort  in  1  synchronous abort to IDLE
- num_steps  in  CNT_W  steps to run, latched at start
- init_x, init_y, init_z  in  W each  initial state, latched at start
- sigma, rho, beta, dt  in  W each  parameters, latched at start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last sample handshake
- out_valid  out  1  sample valid
- out_ready  in  1  downstream ready
- out_x, out_y, out_z  out  W each  sample state
- step_idx  out  CNT_W  1-based index of the sample on out_*

## Operation
- Reset: all outputs 0, state IDLE, internal state and latched parameters 0.
- States: IDLE, MUL (sub-index k = 0..6), UPD, OUT, FIN.
- IDLE: start=1 and abort=0 -> latch inputs, clear step counter; num_steps=0 -> FIN, else MUL k=0.
- MUL, one product per cycle, registered: k0 sigma·(y−x); k1 x·(rho−z); k2 x·y; k3 beta·z; k4 dt·dx with dx=p0; k5 dt·dy with dy=p1−y; k6 dt·dz with dz=p2−p3. k6 -> UPD.
- UPD: x+=p4, y+=p5, z+=p6; copy to out_*, increment step_idx -> OUT.
- OUT: out_valid=1, out_* and step_idx stable. On out_valid&out_ready: step_idx<num_steps -> MUL k=0, else FIN.
- FIN: done=1 for one cycle -> IDLE.
- Arithmetic: product is full 2W signed, arithmetic shift right FRAC (floor), then narrowed to W; differences and sums are W-bit. Overflow behaviour per Configuration.
- start while busy: ignored. abort in any state: IDLE next edge, out_valid drops, no done; abort beats a simultaneous start. Outputs out_* hold last values after abort.
- reset_n low mid-run: same as reset, overrides abort/start.

## Timing
- start sampled at edge 1 -> out_valid high after edge 9 (7 MUL + UPD + OUT entry).
- out_ready held high: one sample per 9 cycles; out_valid high exactly one cycle per sample.
- out_ready low: OUT holds indefinitely, no state advance.
- done pulses the cycle after the final handshake; busy falls with it (IDLE the following cycle).
- num_steps=0: FIN after edge 1, done high one cycle, no out_valid.

## Configuration
- LORENZ_CLAMP_EN defined: every narrowing (products, differences, state sums) saturates to 0x7FFF_FFFF / 0x8000_0000 (at W=32).
- Undefined: plain two's-complement wrap (low W bits).

## Structure
- lorenz_pkg: W, FRAC, CNT_W defaults; state enum; product-index encoding k0..k6; saturating-narrow function shared with other fixed-point blocks.
- Sub-module lorenz_fx_mul: signed W×W multiply, shift, narrow (wrap or clamp by macro); purely combinational, output registered by the sequencer.

## Test plan
- sigma=10.0 (0x000A_0000), rho=28.0, beta=0x0002_AAAB, dt=0x0000_028F, init 1.0/1.0/1.0, num_steps=1, out_ready=1 -> out_valid after edge 9 with x=0x0001_0000, y=0x0001_4286, z=0x0000_FBBC, step_idx=1; done next cycle.
- Same, num_steps=3, out_ready toggled low 5 cycles on each sample -> three samples step_idx 1,2,3, out_* stable while stalled, done once.
- num_steps=0 -> done one cycle after start, out_valid never high.
- abort during MUL k=3 of step 2 -> IDLE next edge, no done, busy low; new start accepted afterwards and reproduces scenario 1 values.
- init x=0, y=0x7FFF_0000, z=0, sigma=2.0, rho=beta=0, dt=1.0 -> with LORENZ_CLAMP_EN out_x=0x7FFF_FFFF; without, out_x=0xFFFE_0000.
- reset_n low in OUT with out_valid high -> next cycle all outputs 0, IDLE; start while busy ignored (step_idx unaffected).
